// File: rtl/block_dispatcher.sv
// Thread-block dispatcher: captures a kernel launch, deals block IDs round-robin
// to NUM_CORES cores (up to DISPATCH_MAX per cycle), counts completions and
// raises a level done when every block of the kernel has finished.
module block_dispatcher #(
   parameter int NUM_CORES    = 4,
   parameter int DATA_W       = 8,
   parameter int DISPATCH_MAX = 1
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              start,
   input  logic                              abort,
   input  logic [DATA_W-1:0]                 num_blocks,
   input  logic [NUM_CORES-1:0]              core_done,
   output logic [NUM_CORES-1:0]              core_start,
   output logic [NUM_CORES-1:0]              core_reset,
   output logic [NUM_CORES-1:0][DATA_W-1:0]  core_block_id,
   output logic [DATA_W-1:0]                 blocks_done,
   output logic                              busy,
   output logic                              done
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

   state_t                            r_state, w_state_nxt;
   logic [DATA_W-1:0]                 r_total, w_total_nxt;
   logic [DATA_W-1:0]                 r_disp, w_disp_nxt;
   logic [DATA_W-1:0]                 r_bd, w_bd_nxt;
   logic [PTR_W-1:0]                  r_rr, w_rr_nxt;
   logic [NUM_CORES-1:0]              r_cs, w_cs_nxt;
   logic [NUM_CORES-1:0]              r_cr, w_cr_nxt;
   logic [NUM_CORES-1:0][DATA_W-1:0]  r_ids, w_ids_nxt;
   logic                              r_busy, w_busy_nxt;
   logic                              r_done, w_done_nxt;

   logic [NUM_CORES-1:0]              w_cmpl;
   logic [DATA_W-1:0]                 w_ncmpl;
   logic [DATA_W-1:0]                 w_bd_sum;
   logic [NUM_CORES-1:0]              w_grant;
   logic [NUM_CORES-1:0][DATA_W-1:0]  w_gid;
   logic [DATA_W:0]                   w_gcnt;
   logic [PTR_W-1:0]                  w_glast;
   logic [PTR_W-1:0]                  w_rr_adv;
   logic [PTR_W:0]                    w_sum;
   logic [PTR_W-1:0]                  w_idx;

   // Completions only count on cores that actually have a block in flight
   always_comb begin
      w_cmpl  = r_cs & core_done;
      w_ncmpl = '0;
      for (int i = 0; i < NUM_CORES; i++)
         w_ncmpl = w_ncmpl + DATA_W'(w_cmpl[i]);
      w_bd_sum = r_bd + w_ncmpl;
   end

   // Round-robin scan from r_rr: grant free cores (reset asserted this cycle) in order,
   // capped by DISPATCH_MAX and by the blocks still left to hand out
   always_comb begin
      w_grant = '0;
      w_gid   = '0;
      w_gcnt  = '0;
      w_glast = r_rr;
      w_sum   = '0;
      w_idx   = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         w_sum = {1'b0, r_rr} + (PTR_W+1)'(j);
         if (w_sum >= (PTR_W+1)'(NUM_CORES))
            w_sum = w_sum - (PTR_W+1)'(NUM_CORES);
         w_idx = w_sum[PTR_W-1:0];
         if (r_cr[w_idx] && (w_gcnt < (DATA_W+1)'(DISPATCH_MAX)) &&
             (({1'b0, r_disp} + w_gcnt) < {1'b0, r_total})) begin
            w_grant[w_idx] = 1'b1;
            w_gid[w_idx]   = r_disp + w_gcnt[DATA_W-1:0];
            w_gcnt         = w_gcnt + 1'b1;
            w_glast        = w_idx;
         end
      end
      w_rr_adv = (w_glast == PTR_W'(NUM_CORES-1)) ? '0 : w_glast + 1'b1;
   end

   // Next-state and next-output logic; abort overrides every state
   always_comb begin
      w_state_nxt = r_state;
      w_total_nxt = r_total;
      w_disp_nxt  = r_disp;
      w_bd_nxt    = r_bd;
      w_rr_nxt    = r_rr;
      w_cs_nxt    = r_cs;
      w_cr_nxt    = r_cr;
      w_ids_nxt   = r_ids;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_cs_nxt    = '0;
         w_cr_nxt    = '1;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cs_nxt = '0;
               w_cr_nxt = '1;
               if (start) begin
                  w_total_nxt = num_blocks;
                  w_disp_nxt  = '0;
                  w_bd_nxt    = '0;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (r_total == '0) begin
                  w_state_nxt = S_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               // A core freed this cycle keeps reset for at least one cycle because
               // grants only look at the registered reset vector
               w_cs_nxt   = (r_cs & ~w_cmpl) | w_grant;
               w_cr_nxt   = (r_cr & ~w_grant) | w_cmpl;
               for (int i = 0; i < NUM_CORES; i++)
                  if (w_grant[i]) w_ids_nxt[i] = w_gid[i];
               w_disp_nxt = r_disp + w_gcnt[DATA_W-1:0];
               if (w_gcnt != '0) w_rr_nxt = w_rr_adv;
               w_bd_nxt   = w_bd_sum;
               if (w_bd_sum == r_total) begin
                  w_state_nxt = S_DONE;
                  w_cs_nxt    = '0;
                  w_cr_nxt    = '1;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
            S_DONE: begin
               // Level start must drop before another kernel can be accepted
               if (!start) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_total <= '0;
         r_disp  <= '0;
         r_bd    <= '0;
         r_rr    <= '0;
         r_cs    <= '0;
         r_cr    <= '1;
         r_ids   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_total <= w_total_nxt;
         r_disp  <= w_disp_nxt;
         r_bd    <= w_bd_nxt;
         r_rr    <= w_rr_nxt;
         r_cs    <= w_cs_nxt;
         r_cr    <= w_cr_nxt;
         r_ids   <= w_ids_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign core_start    = r_cs;
   assign core_reset    = r_cr;
   assign core_block_id = r_ids;
   assign blocks_done   = r_bd;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench: a single-issue dispatcher driven from a cycle table, and a
// four-wide dispatcher exercised by a short hand-written sequence.
module tb_block_dispatcher;

   logic clk;
   logic reset_n;

   logic                 a_start, a_abort;
   logic [7:0]           a_nb;
   logic [3:0]           a_cd;
   logic [3:0]           a_cs, a_cr;
   logic [3:0][7:0]      a_ids;
   logic [7:0]           a_bd;
   logic                 a_busy, a_done;

   logic                 b_start, b_abort;
   logic [7:0]           b_nb;
   logic [3:0]           b_cd;
   logic [3:0]           b_cs, b_cr;
   logic [3:0][7:0]      b_ids;
   logic [7:0]           b_bd;
   logic                 b_busy, b_done;

   int n_checks;
   int n_fail;

   block_dispatcher #(.NUM_CORES(4), .DATA_W(8), .DISPATCH_MAX(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
      .num_blocks(a_nb), .core_done(a_cd), .core_start(a_cs), .core_reset(a_cr),
      .core_block_id(a_ids), .blocks_done(a_bd), .busy(a_busy), .done(a_done));

   block_dispatcher #(.NUM_CORES(4), .DATA_W(8), .DISPATCH_MAX(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
      .num_blocks(b_nb), .core_done(b_cd), .core_start(b_cs), .core_reset(b_cr),
      .core_block_id(b_ids), .blocks_done(b_bd), .busy(b_busy), .done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        ab;
      logic [7:0]  nb;
      logic [3:0]  cd;
      logic [3:0]  cs;
      logic [3:0]  cr;
      logic [31:0] ids;
      logic [7:0]  bd;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic st, input logic ab, input logic [7:0] nb,
                               input logic [3:0] cd, input logic [3:0] cs,
                               input logic [3:0] cr, input logic [31:0] ids,
                               input logic [7:0] bd, input logic busy, input logic done);
      vec_t v;
      v.st = st; v.ab = ab; v.nb = nb; v.cd = cd; v.cs = cs; v.cr = cr;
      v.ids = ids; v.bd = bd; v.busy = busy; v.done = done;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step_b(input logic st, input logic [7:0] nb, input logic [3:0] cd);
      @(negedge clk);
      b_start = st; b_nb = nb; b_cd = cd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      a_start = 1'b0; a_abort = 1'b0; a_nb = 8'd0; a_cd = 4'h0;
      b_start = 1'b0; b_abort = 1'b0; b_nb = 8'd0; b_cd = 4'h0;

      // st ab nb cd | core_start core_reset ids blocks_done busy done
      // Kernel of 6 blocks, each core finishing 3 cycles after it starts
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0000, 4'b0000,4'b1111,32'h00000000,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0000, 4'b0000,4'b1111,32'h00000000,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0000, 4'b0001,4'b1110,32'h00000000,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0000, 4'b0011,4'b1100,32'h00000100,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd40,4'b0000, 4'b0111,4'b1000,32'h00020100,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0001, 4'b1110,4'b0001,32'h03020100,8'd1,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0010, 4'b1101,4'b0010,32'h03020104,8'd2,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0100, 4'b1011,4'b0100,32'h03020504,8'd3,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b1000, 4'b0011,4'b1100,32'h03020504,8'd4,1'b1,1'b0));
      // core 2 is free: its core_done must be ignored
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0101, 4'b0010,4'b1101,32'h03020504,8'd5,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0010, 4'b0000,4'b1111,32'h03020504,8'd6,1'b0,1'b1));
      // start held high in DONE: no relaunch
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd6,1'b0,1'b1));
      tv.push_back(mk(1'b1,1'b0,8'd6, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd6,1'b0,1'b1));
      tv.push_back(mk(1'b0,1'b0,8'd6, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd6,1'b0,1'b0));
      tv.push_back(mk(1'b0,1'b0,8'd6, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd6,1'b0,1'b0));
      // Empty kernel: done two cycles after start
      tv.push_back(mk(1'b1,1'b0,8'd0, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd0, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd0,1'b0,1'b1));
      tv.push_back(mk(1'b0,1'b0,8'd0, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd0,1'b0,1'b0));
      // 5-block kernel aborted with 3 blocks in flight; round robin resumes at core 2
      tv.push_back(mk(1'b1,1'b0,8'd5, 4'b0000, 4'b0000,4'b1111,32'h03020504,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd99,4'b0000, 4'b0000,4'b1111,32'h03020504,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd99,4'b0000, 4'b0100,4'b1011,32'h03000504,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd99,4'b0000, 4'b1100,4'b0011,32'h01000504,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd99,4'b0000, 4'b1101,4'b0010,32'h01000502,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b1,8'd99,4'b0100, 4'b0000,4'b1111,32'h01000502,8'd0,1'b0,1'b0));
      tv.push_back(mk(1'b0,1'b0,8'd99,4'b0000, 4'b0000,4'b1111,32'h01000502,8'd0,1'b0,1'b0));
      // Relaunch after abort: IDs restart from 0; two completions in one cycle
      tv.push_back(mk(1'b1,1'b0,8'd2, 4'b0000, 4'b0000,4'b1111,32'h01000502,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd2, 4'b0000, 4'b0000,4'b1111,32'h01000502,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd2, 4'b0000, 4'b0010,4'b1101,32'h01000002,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd2, 4'b0000, 4'b0110,4'b1001,32'h01010002,8'd0,1'b1,1'b0));
      tv.push_back(mk(1'b1,1'b0,8'd2, 4'b0110, 4'b0000,4'b1111,32'h01010002,8'd2,1'b0,1'b1));
      tv.push_back(mk(1'b0,1'b0,8'd2, 4'b0000, 4'b0000,4'b1111,32'h01010002,8'd2,1'b0,1'b0));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.a.cs",   32'(a_cs),   32'h0);
      check("rst.a.cr",   32'(a_cr),   32'hF);
      check("rst.a.ids",  a_ids,       32'h0);
      check("rst.a.bd",   32'(a_bd),   32'h0);
      check("rst.a.busy", 32'(a_busy), 32'h0);
      check("rst.a.done", 32'(a_done), 32'h0);
      check("rst.b.cr",   32'(b_cr),   32'hF);
      @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < tv.size(); k++) begin
         @(negedge clk);
         a_start = tv[k].st; a_abort = tv[k].ab; a_nb = tv[k].nb; a_cd = tv[k].cd;
         @(posedge clk);
         #1;
         check($sformatf("v%0d.cs", k),   32'(a_cs),   32'(tv[k].cs));
         check($sformatf("v%0d.cr", k),   32'(a_cr),   32'(tv[k].cr));
         check($sformatf("v%0d.ids", k),  a_ids,       tv[k].ids);
         check($sformatf("v%0d.bd", k),   32'(a_bd),   32'(tv[k].bd));
         check($sformatf("v%0d.busy", k), 32'(a_busy), 32'(tv[k].busy));
         check($sformatf("v%0d.done", k), 32'(a_done), 32'(tv[k].done));
      end
      @(negedge clk);
      a_start = 1'b0; a_cd = 4'h0;

      // Four-wide dispatch: 8 blocks in two waves
      step_b(1'b1, 8'd8, 4'h0);
      check("b.launch.busy", 32'(b_busy), 32'h1);
      step_b(1'b1, 8'd8, 4'h0);
      check("b.run.cs", 32'(b_cs), 32'h0);
      step_b(1'b1, 8'd8, 4'h0);
      check("b.w1.cs",  32'(b_cs), 32'hF);
      check("b.w1.cr",  32'(b_cr), 32'h0);
      check("b.w1.ids", b_ids,     32'h03020100);
      step_b(1'b1, 8'd8, 4'hF);
      check("b.c1.bd",  32'(b_bd), 32'h4);
      check("b.c1.cs",  32'(b_cs), 32'h0);
      check("b.c1.cr",  32'(b_cr), 32'hF);
      step_b(1'b1, 8'd8, 4'h0);
      check("b.w2.cs",  32'(b_cs), 32'hF);
      check("b.w2.ids", b_ids,     32'h07060504);
      step_b(1'b1, 8'd8, 4'hF);
      check("b.c2.bd",   32'(b_bd),   32'h8);
      check("b.c2.done", 32'(b_done), 32'h1);
      check("b.c2.busy", 32'(b_busy), 32'h0);
      step_b(1'b0, 8'd8, 4'h0);
      check("b.idle.done", 32'(b_done), 32'h0);

      // Relaunch, then pull reset_n between clock edges while blocks are in flight
      step_b(1'b1, 8'd8, 4'h0);
      step_b(1'b1, 8'd8, 4'h0);
      step_b(1'b1, 8'd8, 4'h0);
      step_b(1'b1, 8'd8, 4'hF);
      step_b(1'b1, 8'd8, 4'h0);
      check("b.pre.cs", 32'(b_cs), 32'hF);
      check("b.pre.bd", 32'(b_bd), 32'h4);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst.b.cs",   32'(b_cs),   32'h0);
      check("arst.b.cr",   32'(b_cr),   32'hF);
      check("arst.b.ids",  b_ids,       32'h0);
      check("arst.b.bd",   32'(b_bd),   32'h0);
      check("arst.b.busy", 32'(b_busy), 32'h0);
      check("arst.a.ids",  a_ids,       32'h0);
      check("arst.a.bd",   32'(a_bd),   32'h0);
      @(negedge clk);
      b_start = 1'b0; b_cd = 4'h0;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post.b.busy", 32'(b_busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
